// File: rtl/proc_in_fifo_pkg.sv
// Shared defaults and helpers for the processor input buffer stage.
package proc_in_fifo_pkg;

  localparam int unsigned DEF_NUBITS = 32;
  localparam int unsigned DEF_NCH    = 2;
  localparam int unsigned DEF_DEPTH  = 16;

  // Width of an index that selects one of n items; never narrower than 1 bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/proc_in_fifo_sync_fifo.sv
// One channel of the input buffer: a register-array FIFO with a synchronous write
// and a combinational head output. level disambiguates full from empty, so the
// pointers simply wrap modulo DEPTH.
module sync_fifo #(
  parameter int NUBITS = 32,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [NUBITS-1:0]          din,
  output logic [NUBITS-1:0]          dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [NUBITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [AW:0]       level_q, level_d;
  logic              do_push;
  logic              do_pop;

  // Guard locally too so a misbehaving parent can never corrupt the pointers.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem_q[rptr_q];

  // Next pointer and occupancy values from this cycle's push/pop pair.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop) level_d = level_q + 1'b1;
    if (!do_push && do_pop) level_d = level_q - 1'b1;
  end

  // Pointer and occupancy registers; reset discards every queued sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Sample storage; contents are meaningless until level says otherwise.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/proc_in_fifo.sv
// Input buffer stage in front of the processor's io_in/req_in port pair.
// Handshake: producer side is valid/ready -- a sample transfers on a rising edge
// where s_valid[k] and s_ready[k] are both high; s_valid may be held while ready
// is low and nothing is consumed. Processor side is strobe-only: req_in[k] is a
// one-cycle read, io_in is valid in the same cycle, and a pop happens at the edge
// if the channel had data (otherwise the last popped value is repeated and the
// channel's sticky underrun flag is set).
module proc_in_fifo
  import proc_in_fifo_pkg::*;
#(
  parameter int NUBITS = DEF_NUBITS,
  parameter int NCH    = DEF_NCH,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NCH*NUBITS-1:0]            s_data,
  input  logic [NCH-1:0]                   s_valid,
  output logic [NCH-1:0]                   s_ready,
  input  logic [NCH-1:0]                   req_in,
  output logic [NUBITS-1:0]                io_in,
  output logic [NCH*($clog2(DEPTH)+1)-1:0] level,
  output logic [NCH-1:0]                   underrun,
  input  logic                             clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = idx_w(NCH);

  logic [NUBITS-1:0] head [NCH];
  logic [NCH-1:0]    full;
  logic [NCH-1:0]    empty;
  logic [NCH-1:0]    pop;

  logic [CW-1:0]     sel_idx;
  logic              sel_any;
  logic              sel_empty;
  logic              rd_ok;

  logic [NUBITS-1:0] hold_q, hold_d;
  logic [NCH-1:0]    underrun_q, underrun_d;

  assign s_ready  = {NCH{~rst}} & ~full;
  assign underrun = underrun_q;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign pop[k] = rd_ok && (sel_idx == CW'(k));

    sync_fifo #(
      .NUBITS (NUBITS),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (s_valid[k] && s_ready[k]),
      .pop   (pop[k]),
      .din   (s_data[k*NUBITS +: NUBITS]),
      .dout  (head[k]),
      .level (level[k*(AW+1) +: (AW+1)]),
      .full  (full[k]),
      .empty (empty[k])
    );
  end

  // Lowest set req_in bit wins; a multi-hot strobe services only that channel.
  always_comb begin
    sel_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req_in[i]) sel_idx = CW'(i);
    end
    sel_any   = |req_in;
    sel_empty = empty[sel_idx];
    rd_ok     = sel_any && !sel_empty;
    io_in     = rd_ok ? head[sel_idx] : hold_q;
  end

  // Hold tracks the last popped sample; underrun sets beat a same-cycle clear.
  always_comb begin
    hold_d     = rd_ok ? head[sel_idx] : hold_q;
    underrun_d = clr_err ? '0 : underrun_q;
    if (sel_any && sel_empty) underrun_d[sel_idx] = 1'b1;
  end

  // Hold register and sticky underrun flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q     <= '0;
      underrun_q <= '0;
    end else begin
      hold_q     <= hold_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_proc_in_fifo.sv
// Directed bench for proc_in_fifo (NUBITS=32, NCH=2, DEPTH=16).
module tb_proc_in_fifo;

  localparam int NUBITS = 32;
  localparam int NCH    = 2;
  localparam int DEPTH  = 16;
  localparam int LW     = 5;

  logic                  clk;
  logic                  rst;
  logic [NCH*NUBITS-1:0] s_data;
  logic [NCH-1:0]        s_valid;
  logic [NCH-1:0]        s_ready;
  logic [NCH-1:0]        req_in;
  logic [NUBITS-1:0]     io_in;
  logic [NCH*LW-1:0]     level;
  logic [NCH-1:0]        underrun;
  logic                  clr_err;

  int checks = 0;
  int errors = 0;
  logic [NUBITS-1:0] exp_q[$];
  logic [NUBITS-1:0] exp_v;

  proc_in_fifo #(.NUBITS(NUBITS), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .req_in   (req_in),
    .io_in    (io_in),
    .level    (level),
    .underrun (underrun),
    .clr_err  (clr_err)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_valid = '0;
    req_in  = '0;
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    s_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (s_ready !== 2'b00) begin errors++; $display("FAIL reset_ready_low: got %b want 00", s_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (s_ready !== 2'b11) begin errors++; $display("FAIL reset_ready_high: got %b want 11", s_ready); end
    checks++;
    if (level !== '0) begin errors++; $display("FAIL reset_level: got %h want 0", level); end
    checks++;
    if (underrun !== 2'b00) begin errors++; $display("FAIL reset_underrun: got %b want 00", underrun); end
    checks++;
    if (io_in !== 32'h0) begin errors++; $display("FAIL reset_io_in: got %h want 0", io_in); end
  endtask

  task automatic test_sign_order();
    s_valid = 2'b01; s_data[31:0] = 32'h0000_0005; step();
    s_data[31:0] = 32'hFFFF_FFFE; step();
    s_valid = 2'b00;
    checks++;
    if (level[4:0] !== 5'd2) begin errors++; $display("FAIL sign_level2: got %0d want 2", level[4:0]); end
    req_in = 2'b01; #1;
    checks++;
    if (io_in !== 32'h0000_0005) begin errors++; $display("FAIL sign_first: got %h want 00000005", io_in); end
    step();
    checks++;
    if (level[4:0] !== 5'd1) begin errors++; $display("FAIL sign_level1: got %0d want 1", level[4:0]); end
    checks++;
    if ($signed(io_in) !== -32'sd2) begin errors++; $display("FAIL sign_second: got %h want fffffffe", io_in); end
    step();
    req_in = 2'b00; #1;
    checks++;
    if (level[4:0] !== 5'd0) begin errors++; $display("FAIL sign_level0: got %0d want 0", level[4:0]); end
    checks++;
    if (io_in !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sign_hold: got %h want fffffffe", io_in); end
    checks++;
    if (underrun !== 2'b00) begin errors++; $display("FAIL sign_no_underrun: got %b want 00", underrun); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      s_valid = 2'b10; s_data[63:32] = 32'd100 + i; step();
    end
    checks++;
    if (level[9:5] !== 5'd16) begin errors++; $display("FAIL full_level: got %0d want 16", level[9:5]); end
    checks++;
    if (s_ready !== 2'b01) begin errors++; $display("FAIL full_ready: got %b want 01", s_ready); end
    s_data[63:32] = 32'd999; step();
    s_valid = 2'b00;
    checks++;
    if (level[9:5] !== 5'd16) begin errors++; $display("FAIL full_refuse: got %0d want 16", level[9:5]); end
    // a pop on a full channel does not let a same-cycle push in
    s_valid = 2'b10; s_data[63:32] = 32'd777; req_in = 2'b10; #1;
    checks++;
    if (io_in !== 32'd100) begin errors++; $display("FAIL full_pop_head: got %0d want 100", io_in); end
    step();
    s_valid = 2'b00;
    checks++;
    if (level[9:5] !== 5'd15) begin errors++; $display("FAIL full_pop_push: got %0d want 15", level[9:5]); end
    for (int i = 1; i < 16; i++) begin
      checks++;
      if (io_in !== 32'd100 + i) begin errors++; $display("FAIL full_drain[%0d]: got %0d want %0d", i, io_in, 100 + i); end
      step();
    end
    req_in = 2'b00; #1;
    checks++;
    if (level[9:5] !== 5'd0) begin errors++; $display("FAIL full_drained: got %0d want 0", level[9:5]); end
    checks++;
    if (underrun !== 2'b00) begin errors++; $display("FAIL full_no_underrun: got %b want 00", underrun); end
  endtask

  task automatic test_wrap();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      exp_v = 32'h3000_0000 + i;
      s_valid = 2'b01; s_data[31:0] = exp_v; exp_q.push_back(exp_v); step();
    end
    // 14 simultaneous push+pop cycles walk both pointers past the wrap point
    for (int i = 3; i < 17; i++) begin
      exp_v = (i % 2 == 1) ? (32'h8000_0000 | i) : (32'h3000_0000 + i);
      s_data[31:0] = exp_v; exp_q.push_back(exp_v);
      req_in = 2'b01; #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (io_in !== exp_v) begin errors++; $display("FAIL wrap_data[%0d]: got %h want %h", i, io_in, exp_v); end
      step();
      checks++;
      if (level[4:0] !== 5'd3) begin errors++; $display("FAIL wrap_level[%0d]: got %0d want 3", i, level[4:0]); end
    end
    s_valid = 2'b00;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      #1;
      checks++;
      if (io_in !== exp_v) begin errors++; $display("FAIL wrap_drain: got %h want %h", io_in, exp_v); end
      step();
    end
    req_in = 2'b00; #1;
    checks++;
    if (level[4:0] !== 5'd0) begin errors++; $display("FAIL wrap_empty: got %0d want 0", level[4:0]); end
  endtask

  task automatic test_underrun();
    s_valid = 2'b01; s_data[31:0] = 32'h1234_5678; step();
    s_valid = 2'b00; req_in = 2'b01; step();
    req_in = 2'b10; #1;
    checks++;
    if (io_in !== 32'h1234_5678) begin errors++; $display("FAIL ur_hold: got %h want 12345678", io_in); end
    step();
    req_in = 2'b00; #1;
    checks++;
    if (underrun !== 2'b10) begin errors++; $display("FAIL ur_set: got %b want 10", underrun); end
    checks++;
    if (level !== '0) begin errors++; $display("FAIL ur_no_ptr_move: got %h want 0", level); end
    clr_err = 1'b1; step();
    clr_err = 1'b0; #1;
    checks++;
    if (underrun !== 2'b00) begin errors++; $display("FAIL ur_clear: got %b want 00", underrun); end
    // set wins over a same-cycle clear
    clr_err = 1'b1; req_in = 2'b10; step();
    clr_err = 1'b0; req_in = 2'b00; #1;
    checks++;
    if (underrun !== 2'b10) begin errors++; $display("FAIL ur_set_wins: got %b want 10", underrun); end
    clr_err = 1'b1; step();
    clr_err = 1'b0;
    // push and read together on an empty channel: stored, no bypass, underrun
    s_valid = 2'b10; s_data[63:32] = 32'h0000_CAFE; req_in = 2'b10; #1;
    checks++;
    if (io_in !== 32'h1234_5678) begin errors++; $display("FAIL ur_no_bypass: got %h want 12345678", io_in); end
    step();
    s_valid = 2'b00; #1;
    checks++;
    if (underrun !== 2'b10) begin errors++; $display("FAIL ur_push_read: got %b want 10", underrun); end
    checks++;
    if (level[9:5] !== 5'd1) begin errors++; $display("FAIL ur_stored: got %0d want 1", level[9:5]); end
    checks++;
    if (io_in !== 32'h0000_CAFE) begin errors++; $display("FAIL ur_stored_head: got %h want 0000cafe", io_in); end
    step();
    req_in = 2'b00; clr_err = 1'b1; step();
    clr_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    req_in = 2'b10; step();
    req_in = 2'b00;
    for (int i = 0; i < 4; i++) begin
      s_valid = 2'b01; s_data[31:0] = 32'h5500_0000 + i; step();
    end
    rst = 1'b1; #1;
    checks++;
    if (s_ready !== 2'b00) begin errors++; $display("FAIL rst_mid_ready: got %b want 00", s_ready); end
    step();
    rst = 1'b0; s_valid = 2'b00; #1;
    checks++;
    if (level !== '0) begin errors++; $display("FAIL rst_mid_level: got %h want 0", level); end
    checks++;
    if (underrun !== 2'b00) begin errors++; $display("FAIL rst_mid_underrun: got %b want 00", underrun); end
    checks++;
    if (io_in !== 32'h0) begin errors++; $display("FAIL rst_mid_io_in: got %h want 0", io_in); end
    checks++;
    if (s_ready !== 2'b11) begin errors++; $display("FAIL rst_mid_ready_after: got %b want 11", s_ready); end
  endtask

  task automatic test_multihot();
    s_valid = 2'b11; s_data = {32'h0000_0022, 32'h0000_0011}; step();
    s_valid = 2'b00; req_in = 2'b11; #1;
    checks++;
    if (io_in !== 32'h0000_0011) begin errors++; $display("FAIL multi_head: got %h want 00000011", io_in); end
    step();
    req_in = 2'b00; #1;
    checks++;
    if (level !== {5'd1, 5'd0}) begin errors++; $display("FAIL multi_levels: got %h want %h", level, {5'd1, 5'd0}); end
    req_in = 2'b10; #1;
    checks++;
    if (io_in !== 32'h0000_0022) begin errors++; $display("FAIL multi_ch1: got %h want 00000022", io_in); end
    step();
    req_in = 2'b00; #1;
    checks++;
    if (underrun !== 2'b00) begin errors++; $display("FAIL multi_underrun: got %b want 00", underrun); end
  endtask

  initial begin
    test_reset();
    test_sign_order();
    test_full();
    test_wrap();
    test_underrun();
    test_reset_mid();
    test_multihot();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
